mix_datapath_pipe: RTL and testbench
====================================

# mix_datapath_pipe

Parametrised, pipelined successor of the 6-bit combinational mixing datapath. Each input word goes through the same expand / select / multiply-fold / XOR chain, now generalised to `WIDTH` bits with a programmable key constant. The chain is split into three register stages behind a valid/ready handshake with full backpressure. An optional per-beat XOR-accumulate mode is new. The block sits between a stimulus source and any sink that can stall.

## Interface
- `WIDTH`, default 6: data width. Legal range is 3 to 32.
- `KEY`, default 3441: key constant. Only bits `[WIDTH:0]` are used; call this slice `K`.

- `clk`, input, 1: sole clock, rising edge.
- `rst`, input, 1: reset. Asynchronous and active-high.
- `in_valid`, input, 1: `in_data` and `in_acc` are valid this cycle.
- `in_ready`, output, 1: the block accepts a beat this cycle.
- `in_data`, input, `WIDTH`: operand `x`.
- `in_acc`, input, 1: the beat uses accumulate mode. It travels with the data.
- `acc_clr`, input, 1: synchronous clear of the accumulator.
- `out_valid`, output, 1: `out_data` holds a result.
- `out_ready`, input, 1: the sink takes the result this cycle.
- `out_data`, output, `WIDTH`: result.

## Operation
All arithmetic is unsigned and truncated to the destination width.

- **Stage 1** registers `x`, the mode bit, and `a = {x,1'b0}` (`WIDTH+1` bits, equal to `2x`).
- **Stage 2** computes:
  - `b` (`WIDTH+1` bits) = `x[1] ? (a ^ (a>>2)) : ((a*a)[WIDTH:0] + x)`.
  - `c` (`WIDTH+1` bits) = `(a != 0) ? K : b`.
  - It registers `a`, `b`, `c` and the mode bit.
- **Stage 3 input**, computed combinationally from the stage-2 registers:
  - `d = ((a+b)*c)[2:0]`.
  - `r = (c ^ d)[WIDTH-1:0]`, with `d` zero-extended.
- **Accumulator** `acc` is a `WIDTH`-bit register.
  - Define `base = acc_clr ? 0 : acc`.
  - When stage 3 loads a beat with mode=1: `out_data <= r ^ base` and `acc <= r ^ base`.
  - When stage 3 loads a beat with mode=0: `out_data <= r`. `acc` is unchanged, except that it goes to 0 if `acc_clr` is high.
  - When no accumulate load happens and `acc_clr` is high: `acc <= 0`.
- **Handshake**
  - `advance = !out_valid || out_ready`. `in_ready = advance`.
  - When `advance` is high, every stage shifts one place. Stage 1 takes the beat if `in_valid` is high; otherwise it takes a bubble.
  - When `advance` is low, all stage registers and all valid bits hold.
  - Bubbles never produce `out_valid` and never touch `acc`.
- `out_data` holds stable while `out_valid && !out_ready`.
- `x = 0` gives `a = b = c = 0` and a result of 0. This is a legal beat, not a bubble.

## Timing
- Reset values: all stage valid bits are 0, `out_valid=0`, `out_data=0`, `acc=0`.
  - `in_ready` is 1 during reset and after it, because it is combinational from `out_valid`.
- Reset asserted mid-operation discards every in-flight beat immediately. It does not wait for a clock edge.
- Latency: a beat accepted in cycle N (`in_valid && in_ready`) has `out_valid` in cycle N+3, provided no stall occurs.
- Throughput is one beat per cycle while `out_ready` stays high.
- Each cycle of `out_ready=0` with `out_valid=1` adds one cycle to the latency of every beat in flight. No beat is dropped or duplicated.
- `in_ready` is combinational from `out_valid` and `out_ready`. No other combinational path from input to output exists.
- When `acc_clr` and an accumulate-mode stage-3 load fall in the same cycle, the clear applies first: `out_data = r` and `acc = r`.

## Test plan
- **Reset:** assert `rst` asynchronously mid-stream, between clock edges. Required: `out_valid=0` and `out_data=0` immediately, `in_ready=1`. After release, the first accepted beat appears exactly 3 cycles later.
- **Streaming, mode 0, defaults (`K=113`):** present `x` = 1, 2, 0, 63 on consecutive cycles with `out_ready=1`. Required: `out_data` = 54, 48, 0, 54 on consecutive cycles, starting 3 cycles after the first beat.
- **Accumulate:** pulse `acc_clr`, then send `x`=1 with `in_acc=1` and `x`=2 with `in_acc=1`. Required: outputs 54, then 6.
- **Clear collision:** send `x`=2 with `in_acc=1` after a prior accumulation, and assert `acc_clr` in the same cycle as its stage-3 load. Required: output 48 and `acc`=48.
- **Backpressure:** stream 4 beats and hold `out_ready=0` for 5 cycles after the first result. Required: `in_ready=0` while stalled, `out_data` stable, and all 4 results delivered in order with no loss.
- **Width sweep:** run with `WIDTH`=3 and 16 against a reference model, using random traffic and random stalls. Required: bit-exact match.

Source files
------------

// File: rtl/mix_datapath_pipe.sv
// mix_datapath_pipe: three-stage pipelined expand / select / multiply-fold / XOR
// datapath with a valid/ready handshake, full backpressure and an optional
// per-beat XOR-accumulate mode. All arithmetic is unsigned and truncating.
module mix_datapath_pipe #(
    parameter int              WIDTH = 6,
    parameter longint unsigned KEY   = 64'd3441
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_acc,
    input  logic             acc_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    // Only the low WIDTH+1 bits of the key take part in the mix.
    localparam logic [WIDTH:0] K = KEY[WIDTH:0];

    // b selects between a shift-XOR fold and a truncated square plus x.
    function automatic logic [WIDTH:0] calc_b(input logic [WIDTH-1:0] x,
                                              input logic [WIDTH:0]   a);
        logic [WIDTH:0] sq;
        sq = a * a;
        if (x[1])
            calc_b = a ^ (a >> 2);
        else
            calc_b = sq + {1'b0, x};
    endfunction

    // r folds the low three bits of (a+b)*c back into c.
    function automatic logic [WIDTH-1:0] calc_r(input logic [WIDTH:0] a,
                                                input logic [WIDTH:0] b,
                                                input logic [WIDTH:0] c);
        logic [WIDTH:0]   s;
        logic [WIDTH:0]   p;
        logic [WIDTH-1:0] d_ext;
        s          = a + b;
        p          = s * c;
        d_ext      = '0;
        d_ext[2:0] = p[2:0];
        calc_r     = c[WIDTH-1:0] ^ d_ext;
    endfunction

    logic             advance;
    logic             load;

    logic             vld_p0;
    logic [WIDTH-1:0] x_p0;
    logic [WIDTH:0]   a_p0;
    logic             mode_p0;

    logic             vld_p1;
    logic [WIDTH:0]   a_p1;
    logic [WIDTH:0]   b_p1;
    logic [WIDTH:0]   c_p1;
    logic             mode_p1;

    logic [WIDTH:0]   b_nx;
    logic [WIDTH:0]   c_nx;
    logic [WIDTH-1:0] r;
    logic [WIDTH-1:0] base;
    logic [WIDTH-1:0] acc;

    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;
    assign load     = advance && vld_p1;

    // Stage-2 combinational mix of the stage-1 registers.
    always_comb begin
        b_nx = calc_b(x_p0, a_p0);
        c_nx = (a_p0 != '0) ? K : b_nx;
    end

    // Stage-3 input and accumulator base; a clear takes precedence over the old value.
    always_comb begin
        r    = calc_r(a_p1, b_p1, c_p1);
        base = acc_clr ? '0 : acc;
    end

    // Valid bits, output register and accumulator; reset flushes every beat in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p0    <= 1'b0;
            vld_p1    <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            acc       <= '0;
        end else begin
            if (advance) begin
                vld_p0    <= in_valid;
                vld_p1    <= vld_p0;
                out_valid <= vld_p1;
            end
            if (load)
                out_data <= mode_p1 ? (r ^ base) : r;
            if (load && mode_p1)
                acc <= r ^ base;
            else if (acc_clr)
                acc <= '0;
        end
    end

    // Data registers of stages 1 and 2; they shift with the valid bits and hold on a stall.
    always_ff @(posedge clk) begin
        if (advance) begin
            // stage 1
            x_p0    <= in_data;
            a_p0    <= {in_data, 1'b0};
            mode_p0 <= in_acc;
            // stage 2
            a_p1    <= a_p0;
            b_p1    <= b_nx;
            c_p1    <= c_nx;
            mode_p1 <= mode_p0;
        end
    end

endmodule

// File: tb/tb_mix_datapath_pipe.sv
// Testbench for mix_datapath_pipe: directed vectors on the default-width
// instance, then randomised traffic on WIDTH=3 and WIDTH=16 instances against
// an arithmetic reference model.
module tb_mix_datapath_pipe;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [5:0] in_data;
    logic       in_acc;
    logic       acc_clr;
    logic       out_valid;
    logic       out_ready;
    logic [5:0] out_data;

    logic        sv  [2];
    logic        sir [2];
    logic        sacc[2];
    logic        sclr[2];
    logic        sov [2];
    logic        sor [2];
    logic [31:0] sdat[2];
    logic [31:0] sod [2];
    logic [2:0]  od3;
    logic [15:0] od16;

    int vec;
    int errs;
    int sx[4];
    int se[4];

    mix_datapath_pipe dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_acc(in_acc), .acc_clr(acc_clr),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
    );

    mix_datapath_pipe #(.WIDTH(3)) u3 (
        .clk(clk), .rst(rst), .in_valid(sv[0]), .in_ready(sir[0]),
        .in_data(sdat[0][2:0]), .in_acc(sacc[0]), .acc_clr(sclr[0]),
        .out_valid(sov[0]), .out_ready(sor[0]), .out_data(od3)
    );

    mix_datapath_pipe #(.WIDTH(16)) u16 (
        .clk(clk), .rst(rst), .in_valid(sv[1]), .in_ready(sir[1]),
        .in_data(sdat[1][15:0]), .in_acc(sacc[1]), .acc_clr(sclr[1]),
        .out_valid(sov[1]), .out_ready(sor[1]), .out_data(od16)
    );

    assign sod[0] = {29'd0, od3};
    assign sod[1] = {16'd0, od16};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Sends n beats from sx back to back and expects se three cycles later.
    task automatic stream(input int n, input logic m);
        for (int i = 0; i < n + 3; i++) begin
            in_valid = (i < n);
            in_data  = (i < n) ? 6'(sx[i]) : 6'd0;
            in_acc   = m;
            tick();
            if (i < 2)
                chk("lat_ov", 32'(out_valid), 32'd0);
            else if (i < n + 2) begin
                chk("str_ov", 32'(out_valid), 32'd1);
                chk("str_od", 32'(out_data), 32'(se[i-2]));
            end else
                chk("str_end_ov", 32'(out_valid), 32'd0);
        end
        in_valid = 1'b0;
    endtask

    function automatic logic [31:0] ref_r(input int w, input logic [31:0] x);
        longint unsigned m1, mw, k, a, b, c, d;
        m1 = (64'd1 << (w + 1)) - 64'd1;
        mw = (64'd1 << w) - 64'd1;
        k  = 64'd3441 & m1;
        a  = (64'(x) << 1) & m1;
        if (x[1]) b = a ^ (a >> 2);
        else      b = (a * a + 64'(x)) & m1;
        c  = (a != 0) ? k : b;
        d  = ((a + b) * c) & 64'd7;
        return 32'((c ^ d) & mw);
    endfunction

    logic [32:0]  q3[$];
    logic [32:0]  q16[$];
    logic [32:0]  ent;
    logic         adv [2];
    logic         clrp[2];
    logic [31:0]  prev[2];
    logic [31:0]  accm[2];
    logic [31:0]  rr;
    logic [31:0]  ee;
    logic [31:0]  bs;
    int           wd;

    initial begin
        vec = 0; errs = 0;
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_acc = 1'b0;
        acc_clr = 1'b0; out_ready = 1'b1;
        for (int j = 0; j < 2; j++) begin
            sv[j] = 1'b0; sacc[j] = 1'b0; sclr[j] = 1'b0; sor[j] = 1'b1;
            sdat[j] = '0; accm[j] = '0; prev[j] = '0;
        end

        // reset state
        #12;
        chk("rst_ov", 32'(out_valid), 32'd0);
        chk("rst_od", 32'(out_data), 32'd0);
        chk("rst_ir", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // mode-0 streaming
        sx = '{1, 2, 0, 63};
        se = '{54, 48, 0, 54};
        stream(4, 1'b0);

        // accumulate after a clear pulse
        acc_clr = 1'b1;
        tick();
        acc_clr = 1'b0;
        sx = '{1, 2, 0, 0};
        se = '{54, 6, 0, 0};
        stream(2, 1'b1);

        // clear landing on the same cycle as an accumulate load
        in_valid = 1'b1; in_data = 6'd2; in_acc = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        acc_clr = 1'b1;
        tick();
        acc_clr = 1'b0;
        chk("clr_ov", 32'(out_valid), 32'd1);
        chk("clr_od", 32'(out_data), 32'd48);
        sx = '{1, 0, 0, 0};
        se = '{6, 0, 0, 0};
        stream(1, 1'b1);

        // backpressure
        in_acc = 1'b0;
        in_valid = 1'b1; in_data = 6'd5;  tick();
        in_data = 6'd10; tick();
        in_data = 6'd12; tick();
        chk("bp_first_ov", 32'(out_valid), 32'd1);
        chk("bp_first_od", 32'(out_data), 32'd50);
        out_ready = 1'b0;
        in_data = 6'd33;
        #1;
        chk("bp_ir_stall", 32'(in_ready), 32'd0);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("bp_hold_ov", 32'(out_valid), 32'd1);
            chk("bp_hold_od", 32'(out_data), 32'd50);
            chk("bp_hold_ir", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_ir_release", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        chk("bp_od2", 32'(out_data), 32'd52);
        tick();
        chk("bp_od3", 32'(out_data), 32'd53);
        tick();
        chk("bp_od4", 32'(out_data), 32'd54);
        chk("bp_ov4", 32'(out_valid), 32'd1);
        tick();
        chk("bp_drain_ov", 32'(out_valid), 32'd0);

        // asynchronous reset mid-stream
        in_valid = 1'b1; in_data = 6'd1;
        tick(); tick(); tick();
        chk("pre_rst_ov", 32'(out_valid), 32'd1);
        in_valid = 1'b0;
        #3;
        rst = 1'b1;
        #1;
        chk("arst_ov", 32'(out_valid), 32'd0);
        chk("arst_od", 32'(out_data), 32'd0);
        chk("arst_ir", 32'(in_ready), 32'd1);
        #2;
        rst = 1'b0;
        in_valid = 1'b1; in_data = 6'd2;
        tick();
        in_valid = 1'b0;
        chk("post_rst_ov1", 32'(out_valid), 32'd0);
        tick();
        chk("post_rst_ov2", 32'(out_valid), 32'd0);
        tick();
        chk("post_rst_ov3", 32'(out_valid), 32'd1);
        chk("post_rst_od3", 32'(out_data), 32'd48);
        tick();
        chk("post_rst_ov4", 32'(out_valid), 32'd0);

        // width sweep with random traffic and stalls
        for (int cyc = 0; cyc < 420; cyc++) begin
            for (int j = 0; j < 2; j++) begin
                sv[j]   = (cyc < 400) && ($urandom_range(0, 9) < 7);
                sdat[j] = (j == 0) ? ($urandom & 32'h7) : ($urandom & 32'hFFFF);
                sacc[j] = 1'($urandom_range(0, 1));
                sclr[j] = ($urandom_range(0, 7) == 0);
                sor[j]  = (cyc >= 400) || ($urandom_range(0, 9) < 7);
            end
            #1;
            for (int j = 0; j < 2; j++) begin
                adv[j]  = !sov[j] || sor[j];
                clrp[j] = sclr[j];
                prev[j] = sod[j];
                if (sv[j] && sir[j]) begin
                    if (j == 0) q3.push_back({sacc[j], sdat[j]});
                    else        q16.push_back({sacc[j], sdat[j]});
                end
            end
            tick();
            for (int j = 0; j < 2; j++) begin
                wd = (j == 0) ? 3 : 16;
                if (adv[j] && sov[j]) begin
                    if ((j == 0 && q3.size() == 0) || (j == 1 && q16.size() == 0)) begin
                        chk("sweep_extra_beat", 32'd1, 32'd0);
                    end else begin
                        ent = (j == 0) ? q3.pop_front() : q16.pop_front();
                        rr  = ref_r(wd, ent[31:0]);
                        bs  = clrp[j] ? 32'd0 : accm[j];
                        ee  = ent[32] ? (rr ^ bs) : rr;
                        if (ent[32])      accm[j] = ee;
                        else if (clrp[j]) accm[j] = 32'd0;
                        chk((j == 0) ? "sweep_w3_od" : "sweep_w16_od", sod[j], ee);
                    end
                end else begin
                    if (clrp[j]) accm[j] = 32'd0;
                    if (!adv[j])
                        chk((j == 0) ? "sweep_w3_hold" : "sweep_w16_hold", sod[j], prev[j]);
                end
            end
        end
        chk("sweep_w3_lost", 32'(q3.size()), 32'd0);
        chk("sweep_w16_lost", 32'(q16.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
